// File: rtl/paralelo_serial_tx_pkg.sv
// Shared line constants and transmitter state encoding for the serial link.
// The receive-side sync detector imports the same comma/idle values.
package paralelo_serial_tx_pkg;

  localparam logic [7:0] CommaByte = 8'hBC;
  localparam logic [7:0] IdleByte  = 8'h7C;

  typedef enum logic {
    StSync   = 1'b0,
    StActive = 1'b1
  } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: MSB-first shifter that sends a comma burst
// after reset, then user bytes via valid/ready or idle fill when none offered.
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
#(
  parameter int unsigned NUM_COMMA = 4,
  parameter logic [7:0]  COMMA     = CommaByte,
  parameter logic [7:0]  IDLE      = IdleByte
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);

  localparam logic [3:0] CommaLast = 4'(NUM_COMMA - 1);

  tx_state_e  state_q;
  logic [7:0] shreg_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] comma_cnt_q;
  logic       data_out_q;

  logic       last_bit;
  logic       sync_done;
  logic [7:0] active_byte;

  always_comb begin
    last_bit    = (bit_cnt_q == 3'd7);
    sync_done   = (comma_cnt_q == CommaLast);
    active_byte = valid_in ? data_in : IDLE;
    // Depends on registers and reset only, so upstream may wait on it combinationally.
    ready_out   = reset && last_bit && ((state_q == StActive) || sync_done);
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q     <= StSync;
      shreg_q     <= COMMA;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      data_out_q  <= 1'b0;
    end else begin
      data_out_q <= shreg_q[3'd7 - bit_cnt_q];
      bit_cnt_q  <= bit_cnt_q + 3'd1;
      if (last_bit) begin
        unique case (state_q)
          StSync: begin
            if (sync_done) begin
              state_q <= StActive;
              shreg_q <= active_byte;
            end else begin
              comma_cnt_q <= comma_cnt_q + 4'd1;
              shreg_q     <= COMMA;
            end
          end
          StActive: shreg_q <= active_byte;
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign active_out = (state_q == StActive);

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: byte-level reference model feeding a bit queue
// that is compared against the serial output on every edge.
module tb_paralelo_serial_tx;

  localparam int NC = 4;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLE  = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, data_out, active_out;

  logic       reset1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       valid1 = 1'b0;
  logic       ready1, dout1, active1;

  int n_checks = 0;
  int n_fail = 0;
  int mcnt = 0;
  logic exp_q[$];
  logic q1[$];

  always #5 clk_32f = ~clk_32f;

  paralelo_serial_tx #(.NUM_COMMA(NC)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .active_out(active_out)
  );

  paralelo_serial_tx #(.NUM_COMMA(1)) dut1 (
    .clk_32f   (clk_32f),
    .reset     (reset1),
    .data_in   (data1),
    .valid_in  (valid1),
    .ready_out (ready1),
    .data_out  (dout1),
    .active_out(active1)
  );

  function automatic logic model_ready();
    return ((mcnt % 8) == 7) && ((mcnt / 8) >= NC - 1);
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  // One clock of the main DUT: check ready, update model, check bit and active.
  task automatic step(input logic v, input logic [7:0] d, output logic acc);
    logic       er;
    logic       eb;
    logic [7:0] nb;
    valid_in = v;
    data_in  = d;
    er  = model_ready();
    acc = er && v;
    n_checks++;
    if (ready_out !== er) begin
      n_fail++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", mcnt, ready_out, er);
    end
    if ((mcnt % 8) == 7) begin
      nb = ((mcnt / 8) < NC - 1) ? COMMA : (v ? d : IDLE);
      push_byte(nb);
    end
    @(posedge clk_32f);
    #1;
    mcnt++;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty cyc=%0d got=%b exp=<none>", mcnt, data_out);
    end else begin
      eb = exp_q.pop_front();
      if (data_out !== eb) begin
        n_fail++;
        $display("FAIL data_out cyc=%0d got=%b exp=%b", mcnt, data_out, eb);
      end
    end
    n_checks++;
    if (active_out !== (mcnt >= 8 * NC)) begin
      n_fail++;
      $display("FAIL active_out cyc=%0d got=%b exp=%b", mcnt, active_out, mcnt >= 8 * NC);
    end
  endtask

  task automatic hold_reset(input int n);
    reset    = 1'b0;
    valid_in = 1'b0;
    #1;
    n_checks++;
    if (ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_reset got=%b exp=0", ready_out);
    end
    repeat (n) begin
      @(posedge clk_32f);
      #1;
      n_checks++;
      if (data_out !== 1'b0 || active_out !== 1'b0 || ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs got=%b%b%b exp=000", data_out, active_out, ready_out);
      end
    end
    exp_q.delete();
    mcnt  = 0;
    reset = 1'b1;
    push_byte(COMMA);
  endtask

  task automatic test_reset();
    hold_reset(2);
  endtask

  task automatic test_comma_idle();
    logic acc;
    for (int i = 0; i < 8 * NC + 24; i++) step(1'b0, 8'h00, acc);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic acc;
    int   k = 0;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
    for (int i = 0; i < 40 && k < 3; i++) begin
      step(1'b1, bytes[k], acc);
      if (acc) k++;
    end
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL back_to_back_accepted got=%0d exp=3", k);
    end
    for (int i = 0; i < 24; i++) step(1'b0, 8'h00, acc);
  endtask

  task automatic test_ignore_not_ready();
    logic acc;
    for (int i = 0; i < 24; i++) step((mcnt % 8) == 3, 8'h55, acc);
  endtask

  task automatic test_alternate();
    logic [7:0] d;
    logic acc;
    int   p = 0;
    for (int i = 0; i < 40; i++) begin
      d = (p < 2) ? 8'h01 : 8'h02;
      if (model_ready()) begin
        step((p % 2) == 0, d, acc);
        p++;
      end else begin
        step(1'b0, 8'h00, acc);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic acc;
    int   g = 0;
    while (!model_ready() && g < 16) begin
      step(1'b0, 8'h00, acc);
      g++;
    end
    step(1'b1, 8'hF0, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, acc);
    hold_reset(3);
    for (int i = 0; i < 8 * NC + 16; i++) step(1'b0, 8'h00, acc);
  endtask

  task automatic test_num_comma_one();
    logic       eb;
    logic [7:0] b;
    @(posedge clk_32f);
    #1;
    reset1 = 1'b1;
    q1.delete();
    b = COMMA;
    for (int i = 7; i >= 0; i--) q1.push_back(b[i]);
    for (int k = 0; k < 16; k++) begin
      valid1 = (k == 7);
      data1  = 8'hA5;
      n_checks++;
      if (ready1 !== ((k % 8) == 7)) begin
        n_fail++;
        $display("FAIL nc1_ready k=%0d got=%b exp=%b", k, ready1, (k % 8) == 7);
      end
      if (k == 7) begin
        b = 8'hA5;
        for (int i = 7; i >= 0; i--) q1.push_back(b[i]);
      end
      @(posedge clk_32f);
      #1;
      eb = (q1.size() > 0) ? q1.pop_front() : 1'bx;
      n_checks++;
      if (dout1 !== eb) begin
        n_fail++;
        $display("FAIL nc1_data k=%0d got=%b exp=%b", k, dout1, eb);
      end
      n_checks++;
      if (active1 !== (k >= 7)) begin
        n_fail++;
        $display("FAIL nc1_active k=%0d got=%b exp=%b", k, active1, k >= 7);
      end
    end
    valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_comma_idle();
    test_back_to_back();
    test_ignore_not_ready();
    test_alternate();
    test_reset_mid_byte();
    test_num_comma_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
Transmit-side parallel-to-serial stage that produces the serial bitstream consumed by the receive chain's serial_paralelo input (data_in at clk_32f).
- Accepts one byte per 8 clk_32f cycles through a valid/ready handshake.
- Serializes MSB first.
- After reset, emits a fixed burst of 0xBC comma bytes so the receiver can lock. Once active, sends 0x7C idle bytes whenever no valid data is offered.

Parameters:
NUM_COMMA, 4, number of 0xBC bytes sent after reset before data is accepted (legal range 1..15)
COMMA, 8'hBC, synchronization byte
IDLE, 8'h7C, byte sent in ACTIVE when no valid input

Ports:
clk_32f  input  1  bit clock; all logic on rising edge
reset  input  1  synchronous, active-low; sampled on clk_32f rising edge
data_in  input  8  byte to transmit
valid_in  input  1  data_in is valid this cycle
ready_out  input/output: output  1  byte accepted on this edge if valid_in=1
data_out  output  1  serial bit, MSB first
active_out  output  1  high once the comma burst has completed (state ACTIVE)

Behaviour:
- Clocking and reset: one clock (clk_32f); reset is synchronous and active-low.
- Registers: shreg[7:0], bit_cnt[2:0], comma_cnt[3:0], state {SYNC, ACTIVE}, data_out.
- Reset (reset=0 at an edge):
  - shreg=COMMA, bit_cnt=0, comma_cnt=0, state=SYNC.
  - data_out=0, active_out=0.
  - ready_out is low while reset is low.
- Every non-reset edge:
  - data_out <= shreg[7-bit_cnt].
  - bit_cnt <= bit_cnt+1, wrapping 7->0.
- Byte boundary: the edge with bit_cnt==7 loads the next byte into shreg.
- SYNC state, at a byte boundary:
  - If comma_cnt==NUM_COMMA-1: state<=ACTIVE and load per the ACTIVE rule.
  - Otherwise: comma_cnt<=comma_cnt+1 and load COMMA.
  - Result: exactly NUM_COMMA commas precede any data or idle.
- ACTIVE state, at a byte boundary:
  - valid_in=1 -> load data_in (handshake completes).
  - valid_in=0 -> load IDLE.
  - ACTIVE never returns to SYNC except through reset.
- ready_out (combinational from registers only, never from valid_in):
  - = reset && bit_cnt==7 && (state==ACTIVE || comma_cnt==NUM_COMMA-1).
  - One-cycle pulse every 8 cycles.
- active_out = (state==ACTIVE), registered.
- valid_in high while ready_out is low: the byte is ignored (not latched). The upstream stage holds data until ready_out.
- Latency: a byte accepted at edge N appears on data_out bit7..bit0 after edges N+1..N+8.
- Reset mid-byte: the current byte is truncated. The sequence restarts at SYNC with a full NUM_COMMA burst, and the first bit after release is COMMA[7].
- Timing after release (edges E0, E1, ...):
  - data_out carries COMMA bits after E0..E(8*NUM_COMMA-1).
  - First ready_out is high in the cycle before edge E(8*NUM_COMMA-1).

Decomposition:
- Shared package/include: COMMA (8'hBC), IDLE (8'h7C), state encoding SYNC=1'b0, ACTIVE=1'b1. The receive-side sync detector imports the same constants.
- No sub-module needed; the bit counter and shifter stay in one flat module.

Test Plan:
1. Reset low 2 cycles, release, valid_in=0 -> data_out over 32 bits = 10111100 x4, then 01111100 repeated; active_out rises after edge E31; ready_out pulses first before E31, then every 8 cycles.
2. After the comma burst, valid_in=1 constantly with data_in 0xA5, 0x3C, 0xFF -> serial 10100101, 00111100, 11111111 back-to-back, no idle gaps; one byte consumed per ready_out pulse.
3. valid_in pulsed high only in a cycle where ready_out=0 with data_in 0x55 -> byte not sent; 0x7C continues.
4. Alternate valid/invalid at each ready pulse, data 0x01 then 0x02 -> stream 0x01, 0x7C, 0x02, 0x7C.
5. Assert reset at bit 3 of data byte 0xF0 -> data_out=0 during reset; after release, a full 4x0xBC burst precedes any data; active_out=0 until its end.
6. NUM_COMMA=1 instance -> ready_out first high with bit_cnt==7 in the first byte; data loaded at E7 and appears after E8.
